// File: rtl/of_pkg.sv
// Shared constants, tuple layout and FSM state type for the OpenFlow header parser.
package of_pkg;

    localparam int OF_TUPLE_W = 243;

    localparam int W_IN_PORT  = 4;
    localparam int W_DL_SRC   = 48;
    localparam int W_DL_DST   = 48;
    localparam int W_DL_TYPE  = 16;
    localparam int W_VLAN_ID  = 12;
    localparam int W_VLAN_PCP = 3;
    localparam int W_NW_SRC   = 32;
    localparam int W_NW_DST   = 32;
    localparam int W_NW_PROTO = 8;
    localparam int W_NW_TOS   = 8;
    localparam int W_TP_SRC   = 16;
    localparam int W_TP_DST   = 16;

    localparam int POS_TP_DST   = 0;
    localparam int POS_TP_SRC   = 16;
    localparam int POS_NW_TOS   = 32;
    localparam int POS_NW_PROTO = 40;
    localparam int POS_NW_DST   = 48;
    localparam int POS_NW_SRC   = 80;
    localparam int POS_VLAN_PCP = 112;
    localparam int POS_VLAN_ID  = 115;
    localparam int POS_DL_TYPE  = 127;
    localparam int POS_DL_DST   = 143;
    localparam int POS_DL_SRC   = 191;
    localparam int POS_IN_PORT  = 239;

    localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
    localparam logic [15:0] ETH_TYPE_VLAN = 16'h8100;
    localparam logic [7:0]  IP_PROTO_TCP  = 8'd6;
    localparam logic [7:0]  IP_PROTO_UDP  = 8'd17;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_REQ,
        ST_WAIT_ACK
    } of_state_e;

    function automatic logic is_l4_proto(input logic [7:0] proto);
        return (proto == IP_PROTO_TCP) || (proto == IP_PROTO_UDP);
    endfunction

endpackage

// File: rtl/of_tuple_capture.sv
// Byte-offset to match-field capture; fields are committed only when their last byte arrives.
// 802.1Q tag parsing is present only when OF_PARSE_VLAN_EN is defined.
module of_tuple_capture
    import of_pkg::*;
#(
    parameter logic [3:0] PORT_ID = 4'h0
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic                  i_byte_en,
    input  logic [7:0]            i_byte,
    output logic [10:0]           o_cnt,
    output logic [OF_TUPLE_W-1:0] o_tuple
);

    logic [10:0]           r_cnt;
    logic [39:0]           r_sh;
    logic                  r_vlan, r_ip;
    logic [3:0]            r_ihl;
    logic [W_IN_PORT-1:0]  r_in_port;
    logic [W_DL_SRC-1:0]   r_dl_src;
    logic [W_DL_DST-1:0]   r_dl_dst;
    logic [W_DL_TYPE-1:0]  r_dl_type;
    logic [W_VLAN_ID-1:0]  r_vlan_id;
    logic [W_VLAN_PCP-1:0] r_vlan_pcp;
    logic [W_NW_SRC-1:0]   r_nw_src;
    logic [W_NW_DST-1:0]   r_nw_dst;
    logic [W_NW_PROTO-1:0] r_nw_proto;
    logic [W_NW_TOS-1:0]   r_nw_tos;
    logic [W_TP_SRC-1:0]   r_tp_src;
    logic [W_TP_DST-1:0]   r_tp_dst;

    logic [10:0] w_idx, w_l3_off, w_rel, w_l4_off;
    logic [15:0] w_w16;
    logic [31:0] w_w32;
    logic [47:0] w_w48;
    logic        w_l3, w_l4;

    assign w_idx    = i_start ? 11'd0 : r_cnt;
    assign w_w16    = {r_sh[7:0], i_byte};
    assign w_w32    = {r_sh[23:0], i_byte};
    assign w_w48    = {r_sh[39:0], i_byte};
    assign w_l3_off = r_vlan ? 11'd18 : 11'd14;
    assign w_rel    = w_idx - w_l3_off;
    assign w_l3     = r_ip && (w_idx >= w_l3_off);
    assign w_l4_off = {5'd0, r_ihl, 2'b00};
    assign w_l4     = w_l3 && is_l4_proto(r_nw_proto) && (r_ihl >= 4'd5);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt      <= '0;
            r_sh       <= '0;
            r_vlan     <= 1'b0;
            r_ip       <= 1'b0;
            r_ihl      <= '0;
            r_in_port  <= '0;
            r_dl_src   <= '0;
            r_dl_dst   <= '0;
            r_dl_type  <= '0;
            r_vlan_id  <= '0;
            r_vlan_pcp <= '0;
            r_nw_src   <= '0;
            r_nw_dst   <= '0;
            r_nw_proto <= '0;
            r_nw_tos   <= '0;
            r_tp_src   <= '0;
            r_tp_dst   <= '0;
        end else if (i_byte_en) begin
            r_sh  <= {r_sh[31:0], i_byte};
            r_cnt <= (w_idx == 11'h7FF) ? 11'h7FF : w_idx + 11'd1;
            if (i_start) begin
                r_vlan     <= 1'b0;
                r_ip       <= 1'b0;
                r_ihl      <= '0;
                r_in_port  <= PORT_ID;
                r_dl_src   <= '0;
                r_dl_dst   <= '0;
                r_dl_type  <= '0;
                r_vlan_id  <= '0;
                r_vlan_pcp <= '0;
                r_nw_src   <= '0;
                r_nw_dst   <= '0;
                r_nw_proto <= '0;
                r_nw_tos   <= '0;
                r_tp_src   <= '0;
                r_tp_dst   <= '0;
            end else begin
                case (w_idx)
                    11'd5:  r_dl_dst <= w_w48;
                    11'd11: r_dl_src <= w_w48;
                    11'd13: begin
                        r_dl_type <= w_w16;
                        r_ip      <= (w_w16 == ETH_TYPE_IPV4);
`ifdef OF_PARSE_VLAN_EN
                        r_vlan    <= (w_w16 == ETH_TYPE_VLAN);
`endif
                    end
`ifdef OF_PARSE_VLAN_EN
                    11'd15: if (r_vlan) begin
                        r_vlan_pcp <= w_w16[15:13];
                        r_vlan_id  <= w_w16[11:0];
                    end
                    11'd17: if (r_vlan) begin
                        r_dl_type <= w_w16;
                        r_ip      <= (w_w16 == ETH_TYPE_IPV4);
                    end
`endif
                    default: ;
                endcase
                if (w_l3) begin
                    case (w_rel)
                        11'd0:   r_ihl      <= i_byte[3:0];
                        11'd1:   r_nw_tos   <= i_byte;
                        11'd9:   r_nw_proto <= i_byte;
                        11'd15:  r_nw_src   <= w_w32;
                        11'd19:  r_nw_dst   <= w_w32;
                        default: ;
                    endcase
                end
                // L4 ports sit right after the IP options, at 4*IHL from the L3 start
                if (w_l4 && (w_rel == w_l4_off + 11'd1)) r_tp_src <= w_w16;
                if (w_l4 && (w_rel == w_l4_off + 11'd3)) r_tp_dst <= w_w16;
            end
        end
    end

    assign o_cnt = r_cnt;

    assign o_tuple[POS_IN_PORT  +: W_IN_PORT]  = r_in_port;
    assign o_tuple[POS_DL_SRC   +: W_DL_SRC]   = r_dl_src;
    assign o_tuple[POS_DL_DST   +: W_DL_DST]   = r_dl_dst;
    assign o_tuple[POS_DL_TYPE  +: W_DL_TYPE]  = r_dl_type;
    assign o_tuple[POS_VLAN_ID  +: W_VLAN_ID]  = r_vlan_id;
    assign o_tuple[POS_VLAN_PCP +: W_VLAN_PCP] = r_vlan_pcp;
    assign o_tuple[POS_NW_SRC   +: W_NW_SRC]   = r_nw_src;
    assign o_tuple[POS_NW_DST   +: W_NW_DST]   = r_nw_dst;
    assign o_tuple[POS_NW_PROTO +: W_NW_PROTO] = r_nw_proto;
    assign o_tuple[POS_NW_TOS   +: W_NW_TOS]   = r_nw_tos;
    assign o_tuple[POS_TP_SRC   +: W_TP_SRC]   = r_tp_src;
    assign o_tuple[POS_TP_DST   +: W_TP_DST]   = r_tp_dst;

endmodule

// File: rtl/of_header_parser.sv
// Frame FSM, lookup handshake, ack timeout and forwarding result for one receive port.
// Define OF_PARSE_VLAN_EN to enable 802.1Q parsing in the capture stage.
//   state       | meaning
//   ST_IDLE     | waiting for the start of a frame (rx_dv rising)
//   ST_HDR      | frame bytes being captured
//   ST_REQ      | one-cycle lookup request
//   ST_WAIT_ACK | waiting for ack/err or timeout
module of_header_parser
    import of_pkg::*;
#(
    parameter logic [3:0]  PORT_ID     = 4'h0,
    parameter logic [15:0] ACK_TIMEOUT = 16'd1024
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  rx_dv,
    input  logic [7:0]            rx_data,
    output logic                  of_lookup_req,
    output logic [OF_TUPLE_W-1:0] of_lookup_data,
    input  logic                  of_lookup_ack,
    input  logic                  of_lookup_err,
    input  logic [3:0]            of_lookup_fwd_port,
    output logic                  fwd_valid,
    output logic [3:0]            fwd_port,
    output logic                  fwd_err,
    output logic [15:0]           busy_drop_cnt
);

    of_state_e   r_state;
    logic        r_dv_q, r_req, r_fwd_valid, r_fwd_err;
    logic [3:0]  r_fwd_port;
    logic [15:0] r_tmo, r_busy_drop;

    logic [10:0] w_cnt;
    logic        w_rise, w_busy, w_start, w_byte_en;

    // r_dv_q resets high so a frame in flight across reset never looks like a new start
    assign w_rise    = rx_dv && !r_dv_q;
    assign w_busy    = (r_state == ST_REQ) || (r_state == ST_WAIT_ACK);
    assign w_start   = w_rise && (r_state == ST_IDLE);
    assign w_byte_en = w_start || ((r_state == ST_HDR) && rx_dv);

    of_tuple_capture #(
        .PORT_ID (PORT_ID)
    ) u_capture (
        .i_clk     (sys_clk),
        .i_rst_n   (sys_rst),
        .i_start   (w_start),
        .i_byte_en (w_byte_en),
        .i_byte    (rx_data),
        .o_cnt     (w_cnt),
        .o_tuple   (of_lookup_data)
    );

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            r_state     <= ST_IDLE;
            r_dv_q      <= 1'b1;
            r_req       <= 1'b0;
            r_fwd_valid <= 1'b0;
            r_fwd_port  <= '0;
            r_fwd_err   <= 1'b0;
            r_tmo       <= '0;
            r_busy_drop <= '0;
        end else begin
            r_dv_q      <= rx_dv;
            r_req       <= 1'b0;
            r_fwd_valid <= 1'b0;
            case (r_state)
                ST_IDLE: if (w_start) r_state <= ST_HDR;
                ST_HDR: begin
                    if (!rx_dv) begin
                        if (w_cnt >= 11'd14) begin
                            r_state <= ST_REQ;
                            r_req   <= 1'b1;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                ST_REQ, ST_WAIT_ACK: begin
                    if (of_lookup_ack || of_lookup_err ||
                        ((r_state == ST_WAIT_ACK) && (r_tmo == 16'd0))) begin
                        r_state     <= ST_IDLE;
                        r_fwd_valid <= 1'b1;
                        r_fwd_port  <= of_lookup_ack ? of_lookup_fwd_port : 4'd0;
                        r_fwd_err   <= !of_lookup_ack;
                    end else begin
                        r_state <= ST_WAIT_ACK;
                        r_tmo   <= (r_state == ST_REQ) ? ACK_TIMEOUT - 16'd1 : r_tmo - 16'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
            if (w_rise && w_busy && (r_busy_drop != 16'hFFFF))
                r_busy_drop <= r_busy_drop + 16'd1;
        end
    end

    assign of_lookup_req = r_req;
    assign fwd_valid     = r_fwd_valid;
    assign fwd_port      = r_fwd_port;
    assign fwd_err       = r_fwd_err;
    assign busy_drop_cnt = r_busy_drop;

endmodule

// File: tb/tb_of_header_parser.sv
// Scoreboard bench for of_header_parser: directed frames, expected tuples/results queued at issue time.
module tb_of_header_parser;
    import of_pkg::*;

    typedef logic [OF_TUPLE_W-1:0] tuple_t;
    typedef struct packed {
        logic [3:0] port;
        logic       err;
    } fwd_t;

    logic                  sys_clk = 1'b0;
    logic                  sys_rst = 1'b0;
    logic                  rx_dv = 1'b0;
    logic [7:0]            rx_data = 8'd0;
    logic                  of_lookup_req;
    logic [OF_TUPLE_W-1:0] of_lookup_data;
    logic                  of_lookup_ack = 1'b0;
    logic                  of_lookup_err = 1'b0;
    logic [3:0]            of_lookup_fwd_port = 4'd0;
    logic                  fwd_valid;
    logic [3:0]            fwd_port;
    logic                  fwd_err;
    logic [15:0]           busy_drop_cnt;

    int     errors = 0;
    int     checks = 0;
    tuple_t exp_tuple_q[$];
    fwd_t   exp_fwd_q[$];
    logic [7:0] fr[$];

    localparam logic [47:0] MAC_A = 48'h020000000002;
    localparam logic [47:0] MAC_B = 48'h020000000001;

    of_header_parser #(
        .PORT_ID     (4'h0),
        .ACK_TIMEOUT (16'd1024)
    ) dut (
        .sys_clk            (sys_clk),
        .sys_rst            (sys_rst),
        .rx_dv              (rx_dv),
        .rx_data            (rx_data),
        .of_lookup_req      (of_lookup_req),
        .of_lookup_data     (of_lookup_data),
        .of_lookup_ack      (of_lookup_ack),
        .of_lookup_err      (of_lookup_err),
        .of_lookup_fwd_port (of_lookup_fwd_port),
        .fwd_valid          (fwd_valid),
        .fwd_port           (fwd_port),
        .fwd_err            (fwd_err),
        .busy_drop_cnt      (busy_drop_cnt)
    );

    always #4 sys_clk = ~sys_clk;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic tuple_t mk(input logic [47:0] src, input logic [47:0] dst,
                                  input logic [15:0] typ, input logic [11:0] vid,
                                  input logic [2:0] pcp, input logic [31:0] nsrc,
                                  input logic [31:0] ndst, input logic [7:0] proto,
                                  input logic [7:0] tos, input logic [15:0] tps,
                                  input logic [15:0] tpd);
        return {4'h0, src, dst, typ, vid, pcp, nsrc, ndst, proto, tos, tps, tpd};
    endfunction

    // Monitor: compares every request and every result against the queued expectations
    always @(negedge sys_clk) begin : mon
        tuple_t et;
        fwd_t   ef;
        if (of_lookup_req === 1'b1) begin
            chk("req_expected", exp_tuple_q.size() != 0, 1'b1);
            if (exp_tuple_q.size() != 0) begin
                et = exp_tuple_q.pop_front();
                chk("tuple", of_lookup_data, et);
            end
        end
        if (fwd_valid === 1'b1) begin
            chk("fwd_expected", exp_fwd_q.size() != 0, 1'b1);
            if (exp_fwd_q.size() != 0) begin
                ef = exp_fwd_q.pop_front();
                chk("fwd_port", fwd_port, ef.port);
                chk("fwd_err", fwd_err, ef.err);
            end
        end
    end

    task automatic pw(input logic [47:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) fr.push_back(v[8*i +: 8]);
    endtask

    task automatic eth(input logic [47:0] dst, input logic [47:0] src, input logic [15:0] typ);
        fr.delete();
        pw(dst, 6);
        pw(src, 6);
        pw({32'd0, typ}, 2);
    endtask

    task automatic ipv4(input logic [3:0] ihl, input logic [7:0] tos, input logic [7:0] proto,
                        input logic [31:0] src, input logic [31:0] dst);
        fr.push_back({4'h4, ihl});
        fr.push_back(tos);
        pw(48'h0040, 2);
        pw(48'h0, 4);
        fr.push_back(8'h40);
        fr.push_back(proto);
        pw(48'h0, 2);
        pw({16'd0, src}, 4);
        pw({16'd0, dst}, 4);
    endtask

    task automatic pad(input int n);
        while (fr.size() < n) fr.push_back(8'hA5);
    endtask

    task automatic udp_frame();
        eth(MAC_A, MAC_B, 16'h0800);
        ipv4(4'd5, 8'h10, 8'd17, 32'h0A000009, 32'h0A000001);
        pw(48'h03E8, 2);
        pw(48'h07D0, 2);
        pw(48'h000C, 2);
        pw(48'h0000, 2);
        pad(60);
    endtask

    function automatic tuple_t udp_tuple();
        return mk(MAC_B, MAC_A, 16'h0800, 12'h0, 3'd0, 32'h0A000009, 32'h0A000001,
                  8'd17, 8'h10, 16'h03E8, 16'h07D0);
    endfunction

    // Drives fr[], optionally pulsing ack on byte ack_at, then checks req one cycle after rx_dv falls
    task automatic send(input logic exp_req, input int ack_at, input logic [3:0] ack_port);
        foreach (fr[i]) begin
            @(negedge sys_clk);
            rx_dv              = 1'b1;
            rx_data            = fr[i];
            of_lookup_ack      = (i == ack_at);
            of_lookup_fwd_port = (i == ack_at) ? ack_port : 4'd0;
        end
        @(negedge sys_clk);
        rx_dv              = 1'b0;
        rx_data            = 8'd0;
        of_lookup_ack      = 1'b0;
        of_lookup_fwd_port = 4'd0;
        @(negedge sys_clk);
        chk("req_timing", of_lookup_req, exp_req);
    endtask

    task automatic respond(input int delay, input logic ack, input logic err, input logic [3:0] port);
        repeat (delay) @(negedge sys_clk);
        of_lookup_ack      = ack;
        of_lookup_err      = err;
        of_lookup_fwd_port = port;
        @(negedge sys_clk);
        of_lookup_ack      = 1'b0;
        of_lookup_err      = 1'b0;
        of_lookup_fwd_port = 4'd0;
        chk("fwd_valid_timing", fwd_valid, 1'b1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_req"}, of_lookup_req, 1'b0);
        chk({tag, "_data"}, of_lookup_data, '0);
        chk({tag, "_fwd_valid"}, fwd_valid, 1'b0);
        chk({tag, "_fwd_port"}, fwd_port, 4'd0);
        chk({tag, "_fwd_err"}, fwd_err, 1'b0);
        chk({tag, "_drop"}, busy_drop_cnt, 16'd0);
    endtask

    initial begin
        int n;
        #20;
        chk_zero("reset");
        idle(2);
        sys_rst = 1'b1;
        idle(3);

        // UDP/IPv4, ack 3 cycles after req
        udp_frame();
        exp_tuple_q.push_back(udp_tuple());
        exp_fwd_q.push_back({4'b0010, 1'b0});
        send(1'b1, -1, 4'd0);
        respond(3, 1'b1, 1'b0, 4'b0010);
        idle(4);

        // 802.1Q tagged TCP, TCI 0xA064
        eth(MAC_A, MAC_B, 16'h8100);
        pw(48'hA064, 2);
        pw(48'h0800, 2);
        ipv4(4'd5, 8'h00, 8'd6, 32'hC0A80001, 32'hC0A80002);
        pw(48'h0050, 2);
        pw(48'h1F90, 2);
        pad(64);
`ifdef OF_PARSE_VLAN_EN
        exp_tuple_q.push_back(mk(MAC_B, MAC_A, 16'h0800, 12'h064, 3'd5, 32'hC0A80001,
                                 32'hC0A80002, 8'd6, 8'h00, 16'h0050, 16'h1F90));
`else
        exp_tuple_q.push_back(mk(MAC_B, MAC_A, 16'h8100, 12'h0, 3'd0, 32'h0, 32'h0,
                                 8'd0, 8'h00, 16'h0, 16'h0));
`endif
        exp_fwd_q.push_back({4'b1000, 1'b0});
        send(1'b1, -1, 4'd0);
        respond(1, 1'b1, 1'b0, 4'b1000);
        idle(4);

        // IHL=6 TCP: ports after 4 option bytes; err response forces port 0
        eth(MAC_A, MAC_B, 16'h0800);
        ipv4(4'd6, 8'h00, 8'd6, 32'h01020304, 32'h05060708);
        pw(48'h11223344, 4);
        pw(48'h1234, 2);
        pw(48'h5678, 2);
        pad(60);
        exp_tuple_q.push_back(mk(MAC_B, MAC_A, 16'h0800, 12'h0, 3'd0, 32'h01020304,
                                 32'h05060708, 8'd6, 8'h00, 16'h1234, 16'h5678));
        exp_fwd_q.push_back({4'b0000, 1'b1});
        send(1'b1, -1, 4'd0);
        respond(2, 1'b0, 1'b1, 4'b1111);
        idle(4);

        // 10-byte runt and 13-byte frame: no request
        eth(MAC_A, MAC_B, 16'h0800);
        while (fr.size() > 10) void'(fr.pop_back());
        send(1'b0, -1, 4'd0);
        idle(3);
        eth(MAC_A, MAC_B, 16'h0800);
        while (fr.size() > 13) void'(fr.pop_back());
        send(1'b0, -1, 4'd0);
        idle(3);

        // 14-byte frame: request with L2 fields only; ack in req cycle
        eth(MAC_A, MAC_B, 16'h0800);
        exp_tuple_q.push_back(mk(MAC_B, MAC_A, 16'h0800, 12'h0, 3'd0, 32'h0, 32'h0,
                                 8'd0, 8'h00, 16'h0, 16'h0));
        exp_fwd_q.push_back({4'b0011, 1'b0});
        send(1'b1, -1, 4'd0);
        respond(0, 1'b1, 1'b0, 4'b0011);
        idle(4);

        // 60-byte ARP; simultaneous ack and err in the req cycle, ack wins
        eth(48'hFFFFFFFFFFFF, 48'h020000000003, 16'h0806);
        pw(48'h0001, 2);
        pw(48'h0800, 2);
        pad(60);
        exp_tuple_q.push_back(mk(48'h020000000003, 48'hFFFFFFFFFFFF, 16'h0806, 12'h0, 3'd0,
                                 32'h0, 32'h0, 8'd0, 8'h00, 16'h0, 16'h0));
        exp_fwd_q.push_back({4'b0101, 1'b0});
        send(1'b1, -1, 4'd0);
        respond(0, 1'b1, 1'b1, 4'b0101);
        idle(4);

        // IPv4 truncated inside nw_dst: nw_dst and ports stay 0
        eth(MAC_A, MAC_B, 16'h0800);
        ipv4(4'd5, 8'h2C, 8'd17, 32'hAC100001, 32'hAC100002);
        while (fr.size() > 32) void'(fr.pop_back());
        exp_tuple_q.push_back(mk(MAC_B, MAC_A, 16'h0800, 12'h0, 3'd0, 32'hAC100001, 32'h0,
                                 8'd17, 8'h2C, 16'h0, 16'h0));
        exp_fwd_q.push_back({4'b0001, 1'b0});
        send(1'b1, -1, 4'd0);
        respond(0, 1'b1, 1'b0, 4'b0001);
        idle(4);

        // Frame arriving during WAIT_ACK is dropped, even after the ack lands mid-frame
        udp_frame();
        exp_tuple_q.push_back(udp_tuple());
        exp_fwd_q.push_back({4'b0100, 1'b0});
        send(1'b1, -1, 4'd0);
        eth(MAC_B, MAC_A, 16'h0800);
        pad(30);
        send(1'b0, 10, 4'b0100);
        idle(3);
        chk("busy_drop_cnt", busy_drop_cnt, 16'd1);

        // No ack: timeout result 1025 cycles after the req cycle (1024 WAIT_ACK cycles)
        udp_frame();
        exp_tuple_q.push_back(udp_tuple());
        exp_fwd_q.push_back({4'b0000, 1'b1});
        send(1'b1, -1, 4'd0);
        n = 0;
        while (fwd_valid !== 1'b1 && n < 2000) begin
            @(negedge sys_clk);
            n++;
        end
        chk("timeout_latency", n, 1025);
        idle(4);

        // Reset mid-frame: outputs clear at once, remainder of the frame ignored
        udp_frame();
        foreach (fr[i]) begin
            @(negedge sys_clk);
            rx_dv   = 1'b1;
            rx_data = fr[i];
            if (i == 8) begin
                sys_rst = 1'b0;
                #1;
                chk_zero("rst_frame");
            end
            if (i == 12) sys_rst = 1'b1;
        end
        @(negedge sys_clk);
        rx_dv   = 1'b0;
        rx_data = 8'd0;
        @(negedge sys_clk);
        chk("req_after_rst", of_lookup_req, 1'b0);
        idle(4);

        // Reset during WAIT_ACK: no result for the interrupted lookup
        udp_frame();
        exp_tuple_q.push_back(udp_tuple());
        send(1'b1, -1, 4'd0);
        idle(5);
        sys_rst = 1'b0;
        #1;
        chk_zero("rst_wait");
        idle(2);
        sys_rst = 1'b1;
        idle(20);

        // Recovery frame; result held afterwards
        udp_frame();
        exp_tuple_q.push_back(udp_tuple());
        exp_fwd_q.push_back({4'b1001, 1'b0});
        send(1'b1, -1, 4'd0);
        respond(2, 1'b1, 1'b0, 4'b1001);
        idle(5);
        chk("fwd_port_held", fwd_port, 4'b1001);
        chk("drop_after_rst", busy_drop_cnt, 16'd0);
        chk("tuple_q_empty", exp_tuple_q.size(), 0);
        chk("fwd_q_empty", exp_fwd_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
